// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared definitions for the multiplexed seven-segment driver:
//             segment codes, the nibble-to-segment decoder, a power-of-ten
//             helper and the converter state encoding.
//  Ports    : (package - none)
//  Revision : 1.0  initial release
// ============================================================================
package display_pkg;

  // Active-high segment patterns, bits 6..0
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h74;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h6F;
  localparam logic [6:0] SEG_7     = 7'h38;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7D;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Converter state encoding
  typedef logic [0:0] conv_state_t;
  localparam conv_state_t ST_IDLE = 1'b0;
  localparam conv_state_t ST_CONV = 1'b1;

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Elaboration-time 10^n, used for the saturation threshold
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : Sequential shift-add-3 binary to BCD converter, one bit per
//             cycle. Values above 10^NUM_DIGITS-1 saturate to all nines.
//  Ports    : clk    - clock
//             rst    - synchronous active-high reset
//             start  - begin conversion (ignored while busy)
//             bin    - binary value, captured on an accepted start
//             busy   - conversion in progress (VALUE_W cycles)
//             done   - high in the last conversion cycle; bcd valid then
//             bcd    - BCD result, NUM_DIGITS nibbles, digit 0 in [3:0]
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int VALUE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int          BCD_W     = 4 * NUM_DIGITS;
  localparam int          CNT_W     = $clog2(VALUE_W + 1);
  localparam logic [63:0] MAX_VALUE = pow10(NUM_DIGITS) - 64'd1;

  conv_state_t              r_state;
  logic [VALUE_W-1:0]       r_bin;
  logic [BCD_W-1:0]         r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_sat;

  logic [BCD_W-1:0]         w_adj;
  logic [BCD_W+VALUE_W-1:0] w_shifted;
  logic [BCD_W-1:0]         w_next_acc;
  logic [VALUE_W-1:0]       w_next_bin;

  // Add 3 to every nibble that would overflow past 9 after doubling
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? (r_acc[4*i +: 4] + 4'd3)
                                                       : r_acc[4*i +: 4];
  end

  assign w_shifted  = {w_adj, r_bin} << 1;
  assign w_next_acc = w_shifted[BCD_W+VALUE_W-1:VALUE_W];
  assign w_next_bin = w_shifted[VALUE_W-1:0];

  assign busy = (r_state == ST_CONV);
  assign done = (r_state == ST_CONV) && (r_cnt == CNT_W'(1));
  // Saturated results may have overflowed the accumulator; override them.
  assign bcd  = r_sat ? {NUM_DIGITS{4'h9}} : w_next_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_CONV;
            r_bin   <= bin;
            r_acc   <= '0;
            r_cnt   <= CNT_W'(VALUE_W);
            r_sat   <= (64'(bin) > MAX_VALUE);
          end
        end
        ST_CONV: begin
          r_bin <= w_next_bin;
          r_acc <= w_next_acc;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/multi_digit_display.sv
`default_nettype none
// ============================================================================
//  Module   : multi_digit_display
//  Purpose  : Multiplexed seven-segment driver. Converts a loaded binary value
//             to BCD, then scans NUM_DIGITS digits at a divided refresh rate
//             with optional leading-zero blanking and whole-display blinking.
//  Ports    : display_clk - sole clock
//             rst         - synchronous active-high reset
//             value       - binary value, sampled on an accepted load
//             load        - load strobe, accepted when busy=0
//             blank_lz    - blank leading zeros (sampled per scan tick)
//             blink_en    - enable blinking (sampled per scan tick)
//             busy        - conversion in progress
//             seg         - registered active-high segment pattern
//             anode       - registered one-hot active-high digit enable
//  Revision : 1.0  initial release
// ============================================================================
module multi_digit_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_TICKS = 128
) (
  input  logic                  display_clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] anode
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic                  w_conv_done;
  logic [BCD_W-1:0]      w_conv_bcd;

  logic [BCD_W-1:0]      r_digits;
  logic [PRE_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [BLK_W-1:0]      r_blink_cnt;
  logic                  r_phase_on;

  logic [BCD_W-1:0]      w_digits_next;
  logic                  w_tick;
  logic [IDX_W-1:0]      w_idx_next;
  logic [NUM_DIGITS-1:0] w_zero_up;
  logic                  w_zero_run;
  logic [3:0]            w_cur_digit;
  logic                  w_cur_blank;
  logic [NUM_DIGITS-1:0] w_anode_next;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk   (display_clk),
    .rst   (rst),
    .start (load),
    .bin   (value),
    .busy  (busy),
    .done  (w_conv_done),
    .bcd   (w_conv_bcd)
  );

  // Forward a completing conversion so a coincident tick shows the new digits
  assign w_digits_next = w_conv_done ? w_conv_bcd : r_digits;

  assign w_tick     = (r_presc == PRE_W'(REFRESH_DIV - 1));
  assign w_idx_next = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : (r_idx + IDX_W'(1));

  // w_zero_up[i]: digit i and every more-significant digit are zero
  always_comb begin
    w_zero_run = 1'b1;
    w_zero_up  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run   = w_zero_run && (w_digits_next[4*i +: 4] == 4'd0);
      w_zero_up[i] = w_zero_run;
    end
  end

  // Select the digit and anode for the index being advanced to
  always_comb begin
    w_cur_digit  = '0;
    w_cur_blank  = 1'b0;
    w_anode_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_next == IDX_W'(i)) begin
        w_cur_digit     = w_digits_next[4*i +: 4];
        w_cur_blank     = blank_lz && (i != 0) && w_zero_up[i];
        w_anode_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge display_clk) begin
    if (rst) begin
      r_digits    <= '0;
      r_presc     <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
      seg         <= SEG_BLANK;
      anode       <= '0;
    end else begin
      r_digits <= w_digits_next;
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= w_idx_next;
        seg     <= w_cur_blank ? SEG_BLANK : nibble_to_seg(w_cur_digit);
        // This tick is displayed with the phase in force before it is counted
        anode   <= (blink_en && !r_phase_on) ? '0 : w_anode_next;
        if (r_blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
          r_blink_cnt <= '0;
          r_phase_on  <= ~r_phase_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
      end else begin
        r_presc <= r_presc + PRE_W'(1);
      end
    end
  end

endmodule : multi_digit_display
`default_nettype wire

// File: doc/multi_digit_display.md
# multi_digit_display

Parametrised multiplexed seven-segment driver for the game's score and countdown readouts. It accepts a binary value on a load strobe and converts it to BCD with a sequential shift-add-3 converter. It then scans NUM_DIGITS digits at a divided refresh rate, with optional leading-zero blanking and whole-display blinking. It replaces fixed two-digit drivers wherever more digits, wider values or blink behaviour are needed.

## Interface
Parameters:
- NUM_DIGITS, 4: digits driven; 1..8.
- VALUE_W, 14: width of the binary input value.
- REFRESH_DIV, 50000: display_clk cycles per scan tick; ≥2.
- BLINK_TICKS, 128: scan ticks per blink half-period; ≥1.

Ports:
- display_clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  VALUE_W  binary value to show; sampled only on an accepted load.
- load  in  1  load strobe; accepted when busy=0.
- blank_lz  in  1  blank leading zeros; sampled every scan tick.
- blink_en  in  1  enable blinking; sampled every scan tick.
- busy  out  1  conversion in progress.
- seg  out  7  active-high segment pattern, registered.
- anode  out  NUM_DIGITS  one-hot active-high digit enable, registered.

## Operation
- Converter FSM has two states, IDLE and CONV.
  - IDLE to CONV: on load=1 with busy=0. Latch value into the shift register, clear the BCD accumulator, and set bit count to VALUE_W.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1 and decrement the count.
  - CONV to IDLE: when the count reaches 0. Copy the accumulator into the display digit registers in the same cycle, all digits at once.
- Loads while busy=1 are ignored. They are not queued.
- Saturation: if value > 10^NUM_DIGITS−1, display all 9s. The comparison uses the latched value at load time.
- Scanning:
  - A prescaler counts 0..REFRESH_DIV−1. The scan tick pulses for one cycle at terminal count.
  - On each tick, the digit index advances 0→1→…→NUM_DIGITS−1→0. Digit 0 is the least significant digit.
  - On each tick, seg and anode are updated together for the new index.
- Leading-zero blanking: with blank_lz=1, digit i is blanked (seg=0, anode bit kept) if it and every more-significant digit are 0. Digit 0 is never blanked, so value 0 shows "0".
- Blinking: a blink counter counts scan ticks. The blink phase toggles every BLINK_TICKS ticks. With blink_en=1 and phase=off, anode=0. With blink_en=0, phase is ignored, but the counter keeps running.
- Segment codes (bits 6..0): 0=7'h3F, 1=7'h30, 2=7'h5B, 3=7'h79, 4=7'h74, 5=7'h6D, 6=7'h6F, 7=7'h38, 8=7'h7F, 9=7'h7D. Any other nibble gives 7'h00.

## Timing
- Reset values:
  - Outputs: busy=0, seg=0, anode=0.
  - Internal: digit registers all 0, index=0, prescaler=0, blink phase=on, FSM in IDLE.
- rst has priority over load and ticks. Asserting rst mid-conversion aborts it, and the display digits return to 0.
- busy rises the cycle after an accepted load and stays high for exactly VALUE_W cycles.
- New digits are visible from the first scan tick after busy falls. Load-to-display latency is at most VALUE_W+1+REFRESH_DIV cycles.
- First output after reset: a tick at cycle REFRESH_DIV shows index 1. Index 0 is shown after NUM_DIGITS ticks.
- A digit-register update and a scan tick in the same cycle: the tick uses the new digits.
- The prescaler and blink counter wrap silently and are never stalled by load.

## Structure
- Package display_pkg holds:
  - the segment code constants, SEG_BLANK, and the nibble-to-segment function;
  - the converter state typedef.
- Sub-module bin2bcd_seq holds the IDLE/CONV shift-add-3 converter. Parameters: VALUE_W, NUM_DIGITS. Ports: start, bin, busy, done, bcd.
- The top level holds the prescaler, scan index, blink counter, blanking and output registers.

## Test plan
- Reset, then load value=1234 with NUM_DIGITS=4 and REFRESH_DIV=4: busy high for 14 cycles. The scan then shows anode 0001/7'h74, 0010/7'h79, 0100/7'h5B, 1000/7'h30, repeating.
- blank_lz=1, load 7: digit 0 shows 7'h38 and digits 1–3 show seg=0. Load 0: digit 0 shows 7'h3F.
- Load 10000 (exceeds 9999): all four digits show 7'h7D.
- Load 42, then load 99 while busy: the second load is ignored. The display settles on 42, and busy falls after 14 cycles.
- blink_en=1, BLINK_TICKS=2: anode is nonzero for 2 ticks and 0 for 2 ticks, alternating.
- Assert rst in the 5th CONV cycle: busy=0, seg=0 and anode=0 next cycle. After the next load, conversion restarts cleanly.
